// File: rtl/joypad_pkg.sv
// joypad_pkg: shared pad widths and NES button bit positions
package joypad_pkg;
  localparam int NES_PAD_BITS = 8;
  localparam int EXT_PAD_BITS = 16;
  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP = 4;
  localparam int BTN_DOWN = 5;
  localparam int BTN_LEFT = 6;
  localparam int BTN_RIGHT = 7;
endpackage

// File: rtl/joypad_channel.sv
// joypad_channel: one serial controller port (shift register, clock edge detect, read counter, overrun)
//   clk, reset (async active-low), strobe: level-sensitive reload, pad_clk: core read clock,
//   load_val: effective buttons, data: serial bit out, read_count: saturating shifts since strobe,
//   overrun: sticky, set when read beyond PAD_BITS
module joypad_channel
  import joypad_pkg::*;
#(
  parameter int PAD_BITS = NES_PAD_BITS,
  parameter logic FILL_BIT = 1'b1,
  parameter int CNT_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                strobe,
  input  logic                pad_clk,
  input  logic [PAD_BITS-1:0] load_val,
  output logic                data,
  output logic [CNT_W-1:0]    read_count,
  output logic                overrun
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PAD_BITS);
  logic [PAD_BITS-1:0] sr;
  logic last_clk;
  logic shift;
  // strobe takes priority, so an edge coinciding with it is dropped
  assign shift = last_clk & ~pad_clk & ~strobe;
  assign data = sr[0];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sr <= '0;
      last_clk <= 1'b0;
      read_count <= '0;
      overrun <= 1'b0;
    end else begin
      last_clk <= pad_clk;
      if (strobe) begin
        sr <= load_val;
        read_count <= '0;
        overrun <= 1'b0;
      end else if (shift) begin
        sr <= {FILL_BIT, sr[PAD_BITS-1:1]};
        read_count <= &read_count ? read_count : read_count + CNT_W'(1);
        if (read_count >= FULL) overrun <= 1'b1;
      end
    end
endmodule

// File: rtl/joypad_serializer.sv
// joypad_serializer: NUM_PADS serial NES controller ports with turbo, fill bits and read counters
//   clk, reset (async active-low), pad_buttons/turbo_mask: per-pad button and autofire bits,
//   frame_tick: turbo time base, joypad_strobe/joypad_clock/joypad_data: core serial interface,
//   read_count/overrun: per-port shift counters and sticky over-read flags
module joypad_serializer
  import joypad_pkg::*;
#(
  parameter int NUM_PADS = 2,
  parameter int PAD_BITS = NES_PAD_BITS,
  parameter logic FILL_BIT = 1'b1,
  parameter int TURBO_FRAMES = 2,
  parameter int CNT_W = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PADS*PAD_BITS-1:0] pad_buttons,
  input  logic [NUM_PADS*PAD_BITS-1:0] turbo_mask,
  input  logic                         frame_tick,
  input  logic                         joypad_strobe,
  input  logic [NUM_PADS-1:0]          joypad_clock,
  output logic [NUM_PADS-1:0]          joypad_data,
  output logic [NUM_PADS*CNT_W-1:0]    read_count,
  output logic [NUM_PADS-1:0]          overrun
);
  localparam int TW = TURBO_FRAMES > 1 ? $clog2(TURBO_FRAMES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TURBO_FRAMES - 1);
  logic [TW-1:0] tcnt;
  logic turbo_phase;
  logic [NUM_PADS*PAD_BITS-1:0] eff;
  // autofire buttons read as released during phase 0
  assign eff = pad_buttons & ~(turbo_mask & {(NUM_PADS*PAD_BITS){~turbo_phase}});
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tcnt <= '0;
      turbo_phase <= 1'b0;
    end else if (frame_tick) begin
      tcnt <= tcnt == TLAST ? '0 : tcnt + TW'(1);
      turbo_phase <= turbo_phase ^ (tcnt == TLAST);
    end
  for (genvar i = 0; i < NUM_PADS; i++) begin : g_ch
    joypad_channel #(
      .PAD_BITS(PAD_BITS),
      .FILL_BIT(FILL_BIT),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .strobe(joypad_strobe),
      .pad_clk(joypad_clock[i]),
      .load_val(eff[i*PAD_BITS +: PAD_BITS]),
      .data(joypad_data[i]),
      .read_count(read_count[i*CNT_W +: CNT_W]),
      .overrun(overrun[i])
    );
  end
endmodule

// File: tb/tb_joypad_serializer.sv
// tb_joypad_serializer: scoreboard bench for joypad_serializer
module tb_joypad_serializer;
  localparam int NP = 2;
  localparam int PB = 8;
  localparam int CW = 5;
  typedef struct {
    int   port;
    logic val;
  } exp_t;
  logic clk = 0;
  logic reset = 0;
  logic [NP*PB-1:0] pad_buttons = '0;
  logic [NP*PB-1:0] turbo_mask = '0;
  logic frame_tick = 0;
  logic joypad_strobe = 0;
  logic [NP-1:0] joypad_clock = '0;
  logic [NP-1:0] joypad_data;
  logic [NP*CW-1:0] read_count;
  logic [NP-1:0] overrun;
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int m_cnt = 0;
  logic m_phase = 0;

  joypad_serializer #(
    .NUM_PADS(NP),
    .PAD_BITS(PB),
    .FILL_BIT(1'b1),
    .TURBO_FRAMES(2),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pad_buttons(pad_buttons),
    .turbo_mask(turbo_mask),
    .frame_tick(frame_tick),
    .joypad_strobe(joypad_strobe),
    .joypad_clock(joypad_clock),
    .joypad_data(joypad_data),
    .read_count(read_count),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_strobe();
    joypad_strobe = 1;
    step();
    joypad_strobe = 0;
  endtask

  task automatic fall(input int p);
    joypad_clock[p] = 1;
    step();
    joypad_clock[p] = 0;
    step();
  endtask

  task automatic push_bits(input int p, input logic [PB-1:0] v, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.port = p;
      e.val = k < PB ? v[k] : 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic frame();
    frame_tick = 1;
    step();
    frame_tick = 0;
    m_phase = m_phase ^ (m_cnt == 1);
    m_cnt = m_cnt == 1 ? 0 : m_cnt + 1;
  endtask

  task automatic hard_reset();
    reset = 0;
    joypad_strobe = 0;
    joypad_clock = '0;
    frame_tick = 0;
    step();
    reset = 1;
    m_cnt = 0;
    m_phase = 0;
    sb.delete();
    step();
  endtask

  task automatic test_reset();
    reset = 0;
    pad_buttons = {8'h3C, 8'h81};
    step();
    step();
    n_vec++;
    if (joypad_data !== 2'b00) begin
      n_err++;
      $display("FAIL reset_data got %b want 00", joypad_data);
    end
    n_vec++;
    if (read_count !== '0) begin
      n_err++;
      $display("FAIL reset_count got %h want 0", read_count);
    end
    n_vec++;
    if (overrun !== 2'b00) begin
      n_err++;
      $display("FAIL reset_overrun got %b want 00", overrun);
    end
    reset = 1;
    step();
  endtask

  task automatic test_basic();
    exp_t e;
    pad_buttons = {8'h3C, 8'h81};
    turbo_mask = '0;
    sb.delete();
    do_strobe();
    for (int k = 0; k < PB; k++) begin
      push_bits(0, 8'h81 >> k, 1);
      push_bits(1, 8'h3C >> k, 1);
    end
    for (int k = 0; k < 2 * PB; k++) begin
      e = sb.pop_front();
      n_vec++;
      if (joypad_data[e.port] !== e.val) begin
        n_err++;
        $display("FAIL basic_bit%0d port%0d got %b want %b", k / 2, e.port, joypad_data[e.port], e.val);
      end
      fall(e.port);
    end
    n_vec++;
    if (read_count !== {5'd8, 5'd8} || overrun !== 2'b00) begin
      n_err++;
      $display("FAIL basic_count got cnt=%h ovr=%b want cnt=108 ovr=00", read_count, overrun);
    end
  endtask

  task automatic test_overrun();
    exp_t e;
    sb.delete();
    push_bits(0, 8'h00, PB + 2);
    for (int k = 0; k < PB; k++) void'(sb.pop_front());
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      fall(0);
      n_vec++;
      if (joypad_data[0] !== e.val) begin
        n_err++;
        $display("FAIL fill_read%0d got %b want %b", k + 9, joypad_data[0], e.val);
      end
      n_vec++;
      if (overrun[0] !== 1'b1) begin
        n_err++;
        $display("FAIL overrun_after%0d got %b want 1", k + 9, overrun[0]);
      end
    end
    n_vec++;
    if (read_count[CW-1:0] !== 5'd10) begin
      n_err++;
      $display("FAIL overrun_count0 got %0d want 10", read_count[CW-1:0]);
    end
    n_vec++;
    if (read_count[2*CW-1:CW] !== 5'd8 || overrun[1] !== 1'b0) begin
      n_err++;
      $display("FAIL port1_isolated got cnt=%0d ovr=%b want cnt=8 ovr=0", read_count[2*CW-1:CW], overrun[1]);
    end
    do_strobe();
    n_vec++;
    if (overrun !== 2'b00 || read_count !== '0) begin
      n_err++;
      $display("FAIL strobe_clear got cnt=%h ovr=%b want 0 00", read_count, overrun);
    end
  endtask

  task automatic test_turbo();
    exp_t e;
    logic [PB-1:0] v;
    hard_reset();
    pad_buttons = {8'h00, 8'h01};
    turbo_mask = {8'h00, 8'h01};
    for (int f = 0; f < 6; f++) begin
      do_strobe();
      v = 8'h01 & ~(8'h01 & {PB{~m_phase}});
      push_bits(0, v, 1);
      e = sb.pop_front();
      n_vec++;
      if (joypad_data[0] !== e.val) begin
        n_err++;
        $display("FAIL turbo_frame%0d got %b want %b", f, joypad_data[0], e.val);
      end
      fall(0);
      frame();
    end
    turbo_mask = '0;
  endtask

  task automatic test_strobe_held();
    pad_buttons = {8'h00, 8'h01};
    joypad_strobe = 1;
    joypad_clock[0] = 1;
    step();
    n_vec++;
    if (joypad_data[0] !== 1'b1) begin
      n_err++;
      $display("FAIL held_load got %b want 1", joypad_data[0]);
    end
    pad_buttons = {8'h00, 8'h00};
    joypad_clock[0] = 0;
    n_vec++;
    if (joypad_data[0] !== 1'b1) begin
      n_err++;
      $display("FAIL held_latency got %b want 1", joypad_data[0]);
    end
    step();
    n_vec++;
    if (joypad_data[0] !== 1'b0 || read_count[CW-1:0] !== 5'd0) begin
      n_err++;
      $display("FAIL held_edge got d=%b cnt=%0d want d=0 cnt=0", joypad_data[0], read_count[CW-1:0]);
    end
    pad_buttons = {8'h00, 8'h01};
    fall(0);
    n_vec++;
    if (joypad_data[0] !== 1'b1 || read_count[CW-1:0] !== 5'd0) begin
      n_err++;
      $display("FAIL held_follow got d=%b cnt=%0d want d=1 cnt=0", joypad_data[0], read_count[CW-1:0]);
    end
    joypad_strobe = 0;
    step();
  endtask

  task automatic test_simul();
    exp_t e;
    pad_buttons = {8'h00, 8'hA5};
    sb.delete();
    joypad_clock[0] = 1;
    step();
    joypad_clock[0] = 0;
    do_strobe();
    n_vec++;
    if (joypad_data[0] !== 1'b1 || read_count[CW-1:0] !== 5'd0) begin
      n_err++;
      $display("FAIL simul_drop got d=%b cnt=%0d want d=1 cnt=0", joypad_data[0], read_count[CW-1:0]);
    end
    push_bits(0, 8'hA5, PB);
    for (int k = 0; k < PB; k++) begin
      e = sb.pop_front();
      n_vec++;
      if (joypad_data[0] !== e.val) begin
        n_err++;
        $display("FAIL simul_bit%0d got %b want %b", k, joypad_data[0], e.val);
      end
      fall(0);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    pad_buttons = {8'hFF, 8'hFF};
    sb.delete();
    do_strobe();
    for (int k = 0; k < 3; k++) fall(0);
    reset = 0;
    #1;
    n_vec++;
    if (joypad_data !== 2'b00 || read_count !== '0 || overrun !== 2'b00) begin
      n_err++;
      $display("FAIL async_reset got d=%b cnt=%h ovr=%b want 00 0 00", joypad_data, read_count, overrun);
    end
    step();
    reset = 1;
    pad_buttons = {8'h00, 8'h5A};
    step();
    do_strobe();
    push_bits(0, 8'h5A, PB);
    for (int k = 0; k < PB; k++) begin
      e = sb.pop_front();
      n_vec++;
      if (joypad_data[0] !== e.val) begin
        n_err++;
        $display("FAIL post_reset_bit%0d got %b want %b", k, joypad_data[0], e.val);
      end
      fall(0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_turbo();
    test_strobe_held();
    test_simul();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
